dcache_refill_ctrl: RTL and testbench

Miss/refill controller sitting directly downstream of the data-cache memory stage. It accepts the stage's miss request (read refill or write-through store), runs the transaction on the external AXI-style memory port, and returns either a full cache line for refill or a write completion. Its `miss_done` pulse clears the stage's pending-miss flag. One request is serviced at a time; no request queueing.

---
 rtl/dcache_refill_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss/refill controller: services one miss at a time, running
// either a B-beat line refill or a single-beat write-through on the memory port.
module dcache_refill_ctrl #(
   parameter int B  = 8,
   parameter int LB = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             miss_req,
   input  logic [63:0]      miss_addr,
   input  logic             miss_write,
   input  logic [2:0]       miss_size,
   input  logic [63:0]      miss_data,
   output logic             miss_done,
   output logic             refill_valid,
   output logic [63:0]      refill_addr,
   output logic [64*B-1:0]  refill_line,
   output logic             bus_err,
   output logic             m_arvalid,
   input  logic             m_arready,
   output logic [63:0]      m_araddr,
   output logic [7:0]       m_arlen,
   input  logic             m_rvalid,
   output logic             m_rready,
   input  logic [63:0]      m_rdata,
   input  logic             m_rlast,
   output logic             m_awvalid,
   input  logic             m_awready,
   output logic [63:0]      m_awaddr,
   output logic             m_wvalid,
   input  logic             m_wready,
   output logic [63:0]      m_wdata,
   output logic [7:0]       m_wstrb,
   input  logic             m_bvalid,
   output logic             m_bready,
   input  logic [1:0]       m_bresp
);

   typedef enum logic [2:0] {IDLE, RD_AR, RD_DATA, WR_REQ, WR_B, DONE} state_t;

   localparam logic [LB-1:0] LAST_BEAT = LB'(B - 1);
   localparam logic [63:0]   LINE_MASK = ~((64'd1 << (LB + 3)) - 64'd1);

   state_t                 state;
   state_t                 state_next;
   logic                   write_q;
   logic [LB-1:0]          beat;
   logic [B-1:0][63:0]     line_q;
   logic                   aw_done;
   logic                   w_done;
   logic                   aw_fin;
   logic                   w_fin;

   // Aligned byte offset of the store within its 64-bit word; 1xx sizes act as sd.
   function automatic logic [2:0] lane_offset(input logic [2:0] size, input logic [2:0] off);
      case (size)
         3'b000:  return off;
         3'b001:  return {off[2:1], 1'b0};
         3'b010:  return {off[2], 2'b00};
         default: return 3'b000;
      endcase
   endfunction

   // Byte-enable mask for the store.
   function automatic logic [7:0] store_strobe(input logic [2:0] size, input logic [2:0] off);
      case (size)
         3'b000:  return 8'h01 << off;
         3'b001:  return 8'h03 << {off[2:1], 1'b0};
         3'b010:  return 8'h0F << {off[2], 2'b00};
         default: return 8'hFF;
      endcase
   endfunction

   assign refill_line = line_q;
   assign aw_fin      = aw_done | (m_awvalid & m_awready);
   assign w_fin       = w_done  | (m_wvalid  & m_wready);

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode and state-decoded outputs.
   always_comb begin
      state_next   = state;
      m_rready     = 1'b0;
      m_bready     = 1'b0;
      miss_done    = 1'b0;
      refill_valid = 1'b0;
      case (state)
         IDLE:    if (miss_req) state_next = miss_write ? WR_REQ : RD_AR;
         RD_AR:   if (m_arvalid && m_arready) state_next = RD_DATA;
         RD_DATA: begin
            m_rready = 1'b1;
            if (m_rvalid && beat == LAST_BEAT) state_next = DONE;
         end
         WR_REQ:  if (aw_fin && w_fin) state_next = WR_B;
         WR_B:    begin
            m_bready = 1'b1;
            if (m_bvalid) state_next = DONE;
         end
         DONE:    begin
            miss_done    = 1'b1;
            refill_valid = ~write_q;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture the request and precompute bus address/data when it is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q     <= 1'b0;
         m_araddr    <= '0;
         m_arlen     <= '0;
         m_awaddr    <= '0;
         m_wdata     <= '0;
         m_wstrb     <= '0;
         refill_addr <= '0;
      end else if (state == IDLE && miss_req) begin
         write_q <= miss_write;
         if (miss_write) begin
            m_awaddr <= {miss_addr[63:3], 3'b000};
            m_wstrb  <= store_strobe(miss_size, miss_addr[2:0]);
            m_wdata  <= miss_data << {lane_offset(miss_size, miss_addr[2:0]), 3'b000};
         end else begin
            m_araddr    <= miss_addr & LINE_MASK;
            m_arlen     <= 8'(B - 1);
            refill_addr <= miss_addr & LINE_MASK;
         end
      end
   end

   // Request-channel valids: raised one cycle after entering the state, held until handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_arvalid <= 1'b0;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         case (state)
            RD_AR:  m_arvalid <= ~(m_arvalid & m_arready);
            WR_REQ: begin
               if (m_awvalid && m_awready) begin
                  m_awvalid <= 1'b0;
                  aw_done   <= 1'b1;
               end else if (!aw_done) begin
                  m_awvalid <= 1'b1;
               end
               if (m_wvalid && m_wready) begin
                  m_wvalid <= 1'b0;
                  w_done   <= 1'b1;
               end else if (!w_done) begin
                  m_wvalid <= 1'b1;
               end
            end
            default: begin
               m_arvalid <= 1'b0;
               m_awvalid <= 1'b0;
               m_wvalid  <= 1'b0;
               aw_done   <= 1'b0;
               w_done    <= 1'b0;
            end
         endcase
      end
   end

   // Beat counter, line buffer and sticky bus-error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat    <= '0;
         line_q  <= '0;
         bus_err <= 1'b0;
      end else begin
         if (state == RD_AR && m_arvalid && m_arready) beat <= '0;
         if (state == RD_DATA && m_rvalid) begin
            line_q[beat] <= m_rdata;
            beat         <= beat + LB'(1);
            if (m_rlast != (beat == LAST_BEAT)) bus_err <= 1'b1;
         end
         if (state == WR_B && m_bvalid && m_bresp != 2'b00) bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed self-checking bench for dcache_refill_ctrl.
module tb_dcache_refill_ctrl;

   localparam int B  = 8;
   localparam int LB = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             miss_req;
   logic [63:0]      miss_addr;
   logic             miss_write;
   logic [2:0]       miss_size;
   logic [63:0]      miss_data;
   logic             miss_done;
   logic             refill_valid;
   logic [63:0]      refill_addr;
   logic [64*B-1:0]  refill_line;
   logic             bus_err;
   logic             m_arvalid, m_arready;
   logic [63:0]      m_araddr;
   logic [7:0]       m_arlen;
   logic             m_rvalid, m_rready, m_rlast;
   logic [63:0]      m_rdata;
   logic             m_awvalid, m_awready;
   logic [63:0]      m_awaddr;
   logic             m_wvalid, m_wready;
   logic [63:0]      m_wdata;
   logic [7:0]       m_wstrb;
   logic             m_bvalid, m_bready;
   logic [1:0]       m_bresp;

   int checks   = 0;
   int failures = 0;
   logic exp_err = 1'b0;

   dcache_refill_ctrl #(.B(B), .LB(LB)) dut (
      .clk(clk), .rst_n(rst_n),
      .miss_req(miss_req), .miss_addr(miss_addr), .miss_write(miss_write),
      .miss_size(miss_size), .miss_data(miss_data),
      .miss_done(miss_done), .refill_valid(refill_valid), .refill_addr(refill_addr),
      .refill_line(refill_line), .bus_err(bus_err),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read refill with a directed slave: gap bits suppress rvalid per slot.
   task automatic do_read(input logic [63:0] addr, input logic [63:0] base,
                          input logic [15:0] gaps, input int last_beat, input bit pre_rv);
      int beat;
      int slot;
      logic [63:0] line_addr;
      line_addr = addr & ~64'(8 * B - 1);
      if (last_beat != B - 1) exp_err = 1'b1;
      miss_addr  = addr;
      miss_write = 1'b0;
      miss_size  = 3'b011;
      miss_data  = '0;
      miss_req   = 1'b1;
      m_arready  = 1'b1;
      m_rvalid   = pre_rv;
      m_rlast    = pre_rv;
      m_rdata    = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      miss_req = 1'b0;
      chk("rd_arvalid_e0", m_arvalid, 0);
      tick();
      chk("rd_arvalid_e1", m_arvalid, 1);
      chk("rd_araddr", m_araddr, line_addr);
      chk("rd_arlen", m_arlen, B - 1);
      tick();
      chk("rd_arvalid_e2", m_arvalid, 0);
      chk("rd_rready", m_rready, 1);
      beat = 0;
      slot = 0;
      while (beat < B && slot < 64) begin
         m_rvalid = (slot >= 16) || !gaps[slot[3:0]];
         m_rdata  = m_rvalid ? base + 64'(beat) : 64'hDEAD_BEEF_DEAD_BEEF;
         m_rlast  = m_rvalid && (beat == last_beat);
         tick();
         if (m_rvalid) beat++;
         slot++;
         if (beat < B) chk("rd_done_early", miss_done, 0);
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      chk("rd_miss_done", miss_done, 1);
      chk("rd_refill_valid", refill_valid, 1);
      chk("rd_refill_addr", refill_addr, line_addr);
      chk("rd_bus_err", bus_err, exp_err);
      for (int i = 0; i < B; i++) chk("rd_word", refill_line[i*64 +: 64], base + 64'(i));
      tick();
      chk("rd_done_drop", miss_done, 0);
      chk("rd_valid_drop", refill_valid, 0);
      chk("rd_line_hold", refill_line[63:0], base);
   endtask

   // Write-through with AW/W handshakes at chosen edges (both >= 2).
   task automatic do_write(input logic [63:0] addr, input logic [2:0] size, input logic [63:0] data,
                           input int aw_edge, input int w_edge, input logic [1:0] resp,
                           input logic [63:0] exp_awaddr, input logic [7:0] exp_strb,
                           input logic [63:0] exp_wdata);
      int last;
      last = (aw_edge > w_edge) ? aw_edge : w_edge;
      if (resp != 2'b00) exp_err = 1'b1;
      miss_addr  = addr;
      miss_write = 1'b1;
      miss_size  = size;
      miss_data  = data;
      miss_req   = 1'b1;
      m_awready  = 1'b0;
      m_wready   = 1'b0;
      m_bvalid   = 1'b0;
      m_bresp    = resp;
      tick();
      miss_req = 1'b0;
      chk("wr_awvalid_e0", m_awvalid, 0);
      chk("wr_wvalid_e0", m_wvalid, 0);
      for (int e = 1; e <= last; e++) begin
         m_awready = (e == aw_edge);
         m_wready  = (e == w_edge);
         tick();
         chk("wr_awvalid", m_awvalid, 64'(e < aw_edge));
         chk("wr_wvalid", m_wvalid, 64'(e < w_edge));
         if (e == 1) begin
            chk("wr_awaddr", m_awaddr, exp_awaddr);
            chk("wr_wstrb", m_wstrb, exp_strb);
         end
         if (e < w_edge) chk("wr_wdata", m_wdata, exp_wdata);
      end
      m_awready = 1'b0;
      m_wready  = 1'b0;
      chk("wr_bready", m_bready, 1);
      chk("wr_done_early", miss_done, 0);
      m_bvalid = 1'b1;
      tick();
      m_bvalid = 1'b0;
      chk("wr_miss_done", miss_done, 1);
      chk("wr_refill_valid", refill_valid, 0);
      chk("wr_bus_err", bus_err, exp_err);
      tick();
      chk("wr_done_drop", miss_done, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      miss_req = 1'b0; miss_addr = '0; miss_write = 1'b0; miss_size = '0; miss_data = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
      tick();
      tick();
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_awvalid", m_awvalid, 0);
      chk("rst_miss_done", miss_done, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_araddr", m_araddr, 0);
      chk("rst_line", 64'(|refill_line), 0);
      rst_n = 1'b1;
      tick();

      // Zero-wait line refill and stores.
      do_read(64'h1000_0048, 64'h100, 16'h0000, B - 1, 1'b0);
      do_write(64'h2006, 3'b001, 64'hABCD, 2, 2, 2'b00, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000);
      do_write(64'h4003, 3'b000, 64'h5A, 2, 2, 2'b00, 64'h4000, 8'h08, 64'h5A00_0000);

      // Handshake skew and rvalid gaps with stray rvalid before the data phase.
      do_write(64'h300C, 3'b010, 64'h1234_5678, 2, 5, 2'b00, 64'h3008, 8'hF0, 64'h1234_5678_0000_0000);
      do_read(64'h2000_01F8, 64'h200, 16'b0000_0100_1010_0010, B - 1, 1'b1);

      // Bus errors: early rlast, then SLVERR on a 1xx-size store.
      do_read(64'h3000, 64'h300, 16'h0000, 5, 1'b0);
      do_write(64'h5005, 3'b111, 64'h1122_3344_5566_7788, 2, 2, 2'b10,
               64'h5000, 8'hFF, 64'h1122_3344_5566_7788);

      // Reset after beat 3 of a burst.
      miss_addr = 64'h5000_0000; miss_write = 1'b0; miss_req = 1'b1; m_arready = 1'b1;
      tick();
      miss_req = 1'b0;
      tick();
      tick();
      m_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_rdata = 64'h700 + 64'(i);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rready", m_rready, 0);
      chk("mid_arvalid", m_arvalid, 0);
      chk("mid_miss_done", miss_done, 0);
      chk("mid_bus_err", bus_err, 0);
      chk("mid_araddr", m_araddr, 0);
      chk("mid_arlen", m_arlen, 0);
      chk("mid_awaddr", m_awaddr, 0);
      chk("mid_wstrb", m_wstrb, 0);
      chk("mid_refill_addr", refill_addr, 0);
      chk("mid_line", 64'(|refill_line), 0);
      m_rvalid = 1'b0;
      exp_err  = 1'b0;
      tick();
      chk("mid_done_hold", miss_done, 0);
      rst_n = 1'b1;
      tick();
      chk("mid_idle_done", miss_done, 0);
      chk("mid_idle_arvalid", m_arvalid, 0);
      do_read(64'h6000_0010, 64'h600, 16'h0000, B - 1, 1'b0);

      // Back-to-back: miss_req held through DONE, ignored there, taken in the next IDLE.
      miss_addr = 64'h7000; miss_write = 1'b1; miss_size = 3'b011; miss_data = 64'h77;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
      miss_req = 1'b1;
      for (int e = 0; e < 9; e++) begin
         logic [8:0] done_pat;
         logic [8:0] awv_pat;
         done_pat = 9'b1_0000_1000;
         awv_pat  = 9'b0_0100_0010;
         tick();
         if (e == 5) miss_req = 1'b0;
         chk("b2b_miss_done", miss_done, 64'(done_pat[e]));
         chk("b2b_awvalid", m_awvalid, 64'(awv_pat[e]));
      end
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      tick();
      chk("b2b_bus_err", bus_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
